// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a two-entry skid buffer, hazard stall and flush-to-NOP.
// Optional saturating stall counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              main_valid, skid_valid;
    logic              accept, drain;

    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == SKID);

    // in_ready depends only on registered state and stall, never on out_ready.
    assign in_ready  = !skid_valid && !stall;
    assign out_valid = main_valid && !stall;
    assign out_data  = main_data_q;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = FLUSH_VAL;
            skid_data_d = FLUSH_VAL;
        end else if (!stall) begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = FULL;
                        main_data_d = in_data;
                    end
                end
                FULL: begin
                    if (accept && drain) begin
                        main_data_d = in_data;
                    end else if (accept) begin
                        state_d     = SKID;
                        skid_data_d = in_data;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (drain) begin
                        state_d     = FULL;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= FLUSH_VAL;
            skid_data_q <= FLUSH_VAL;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts hazard stalls and downstream backpressure; saturates, cleared only by rst.
    always_comb begin
        cnt_d = cnt_q;
        if ((stall || (main_valid && !out_ready)) && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + random bench for pipe_stage_reg against a 2-deep FIFO reference model.
module tb_pipe_stage_reg;
    localparam int            DW   = 16;
    localparam int            CW   = 3;
    localparam logic [DW-1:0] FV   = 16'hA5A5;
    localparam int            CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready, stall, flush;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] stall_count;

    logic [DW-1:0] q[$];
    logic [DW-1:0] hold;
    int            cnt;
    int            vectors     = 0;
    int            miscompares = 0;
    int            sat_exp;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .FLUSH_VAL(FV), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall(stall), .flush(flush), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model, cross the edge.
    task automatic step(input logic r, input logic iv, input logic [DW-1:0] d,
                        input logic ordy, input logic st, input logic fl);
        logic          ir, ov;
        logic [DW-1:0] od;
        int            cexp;
        rst = r; in_valid = iv; in_data = d; out_ready = ordy; stall = st; flush = fl;
        @(negedge clk);
        ir = (q.size() < 2) && !st;
        ov = (q.size() > 0) && !st;
        od = (q.size() > 0) ? q[0] : hold;
`ifdef PIPE_STAGE_STALL_CNT_EN
        cexp = cnt;
`else
        cexp = 0;
`endif
        chk("in_ready", {31'd0, in_ready}, {31'd0, ir});
        chk("out_valid", {31'd0, out_valid}, {31'd0, ov});
        chk("out_data", {16'd0, out_data}, {16'd0, od});
        chk("stall_count", {29'd0, stall_count}, cexp);
        if (r) begin
            q.delete(); hold = FV; cnt = 0;
        end else begin
            if (st || (q.size() > 0 && !ordy)) cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
            if (fl) begin
                q.delete(); hold = FV;
            end else if (!st) begin
                if (ov && ordy) hold = q.pop_front();
                if (iv && ir) q.push_back(d);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] d;
`ifdef PIPE_STAGE_STALL_CNT_EN
        sat_exp = CMAX;
`else
        sat_exp = 0;
`endif
        hold = FV; cnt = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        q.delete(); hold = FV; cnt = 0;

        // reset state and reset-then-stream 1..8
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, {16'd0, FV});
        chk("rst_count", {29'd0, stall_count}, 32'd0);
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // skid fill: A, B absorbed, C held off until out_ready rises
        do_reset();
        step(1'b0, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // stall hold while FULL with 0xDEAD
        do_reset();
        step(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("stall_release_data", {16'd0, out_data}, 32'h0000DEAD);
        @(posedge clk); #1;
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // flush + stall + in_valid from SKID
        do_reset();
        step(1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0055, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // counter saturation, then cleared by rst
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("count_saturated", {29'd0, stall_count}, sat_exp);
        @(posedge clk); #1;
        do_reset();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            d = DW'($urandom);
            step(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1, d,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end
endmodule
